// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the seven-segment display path (segment order a..g = bit 6..0).
// Hex letter patterns are decoded only when SEVENSEG_READER_HEX_EN is defined.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h73;
  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h1F;
  localparam seg_t SEG_C     = 7'h4E;
  localparam seg_t SEG_D     = 7'h3D;
  localparam seg_t SEG_E     = 7'h4F;
  localparam seg_t SEG_F     = 7'h47;

  localparam logic [3:0] ERR_CODE = 4'hF;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } digit_t;

  typedef enum logic {
    SYNC,
    ASSEMBLE
  } frame_state_t;

endpackage

// File: rtl/sevenseg_reader_if.sv
// Display-bus and frame-output bundle of sevenseg_reader; slave is the reader, master drives the display side.
interface sevenseg_reader_if #(
  parameter int NDIGITS = 4
);
  import sevenseg_pkg::*;

  seg_t                   seg_in;
  logic [NDIGITS-1:0]     dig_in;
  logic                   out_ready;
  logic                   out_valid;
  logic [4*NDIGITS-1:0]   out_digits;
  logic [NDIGITS-1:0]     out_blank;
  logic [NDIGITS-1:0]     out_err;
  logic                   overrun;

  modport master (
    output seg_in, dig_in, out_ready,
    input  out_valid, out_digits, out_blank, out_err, overrun
  );

  modport slave (
    input  seg_in, dig_in, out_ready,
    output out_valid, out_digits, out_blank, out_err, overrun
  );

endinterface

// File: rtl/sevenseg_decode.sv
// Combinational segment-pattern to BCD decoder; hex letters A..F accepted when SEVENSEG_READER_HEX_EN is defined.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  seg_t   seg,
  output digit_t digit
);

  always_comb begin
    digit.value = ERR_CODE;
    digit.blank = 1'b0;
    digit.err   = 1'b0;
    case (seg)
      SEG_BLANK: begin
        digit.value = 4'h0;
        digit.blank = 1'b1;
      end
      SEG_0: digit.value = 4'h0;
      SEG_1: digit.value = 4'h1;
      SEG_2: digit.value = 4'h2;
      SEG_3: digit.value = 4'h3;
      SEG_4: digit.value = 4'h4;
      SEG_5: digit.value = 4'h5;
      SEG_6: digit.value = 4'h6;
      SEG_7: digit.value = 4'h7;
      SEG_8: digit.value = 4'h8;
      SEG_9: digit.value = 4'h9;
`ifdef SEVENSEG_READER_HEX_EN
      SEG_A: digit.value = 4'hA;
      SEG_B: digit.value = 4'hB;
      SEG_C: digit.value = 4'hC;
      SEG_D: digit.value = 4'hD;
      SEG_E: digit.value = 4'hE;
      SEG_F: digit.value = 4'hF;
`endif
      default: digit.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Recovers digit values from a scanned seven-segment bus and emits whole frames on a ready/valid output.
// Hex letter decoding is enabled by SEVENSEG_READER_HEX_EN.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  sevenseg_reader_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  seg_t                 seg_q;
  logic [NDIGITS-1:0]   dig_q;
  logic [CW-1:0]        stable_cnt;
  logic [CW-1:0]        cnt_next;
  logic                 onehot_in;
  logic                 same_in;
  logic                 capture;
  logic [IW-1:0]        cap_idx;
  digit_t               cap_digit;

  frame_state_t         state;
  logic [IW-1:0]        expected;
  logic                 accept;
  logic                 complete;
  logic [4*NDIGITS-1:0] stage_digits;
  logic [NDIGITS-1:0]   stage_blank;
  logic [NDIGITS-1:0]   stage_err;
  logic [4*NDIGITS-1:0] merged_digits;
  logic [NDIGITS-1:0]   merged_blank;
  logic [NDIGITS-1:0]   merged_err;

  // The counter compares the incoming pair with the sample register so that a
  // pair first sampled at edge k reaches STABLE_CYCLES at edge k+STABLE_CYCLES-1.
  always_comb begin
    onehot_in = (bus.dig_in != '0) &&
                ((bus.dig_in & (bus.dig_in - NDIGITS'(1))) == '0);
    same_in   = (bus.seg_in == seg_q) && (bus.dig_in == dig_q);
    if (!onehot_in)
      cnt_next = '0;
    else if (!same_in)
      cnt_next = CW'(1);
    else if (stable_cnt == CNT_MAX)
      cnt_next = CNT_MAX;
    else
      cnt_next = stable_cnt + CW'(1);
    capture = (cnt_next == CNT_MAX) && (stable_cnt != CNT_MAX);
  end

  // On a capture the incoming pair equals the sample registers, so decode from those.
  always_comb begin
    cap_idx = '0;
    for (int unsigned i = 0; i < NDIGITS; i++)
      if (dig_q[i]) cap_idx = IW'(i);
  end

  sevenseg_decode u_decode (
    .seg   (seg_q),
    .digit (cap_digit)
  );

  always_comb begin
    merged_digits = stage_digits;
    merged_blank  = stage_blank;
    merged_err    = stage_err;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (cap_idx == IW'(i)) begin
        merged_digits[4*i +: 4] = cap_digit.value;
        merged_blank[i]         = cap_digit.blank;
        merged_err[i]           = cap_digit.err;
      end
    end
  end

  always_comb begin
    accept = 1'b0;
    if (capture) begin
      case (state)
        SYNC:     accept = (cap_idx == '0);
        ASSEMBLE: accept = (cap_idx == expected) || (cap_idx == '0);
        default:  accept = 1'b0;
      endcase
    end
    complete = accept && (cap_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q          <= '0;
      dig_q          <= '0;
      stable_cnt     <= '0;
      state          <= SYNC;
      expected       <= '0;
      stage_digits   <= '0;
      stage_blank    <= '0;
      stage_err      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_digits <= '0;
      bus.out_blank  <= '0;
      bus.out_err    <= '0;
      bus.overrun    <= 1'b0;
    end else begin
      seg_q      <= bus.seg_in;
      dig_q      <= bus.dig_in;
      stable_cnt <= cnt_next;

      if (capture) begin
        if (accept) begin
          stage_digits <= merged_digits;
          stage_blank  <= merged_blank;
          stage_err    <= merged_err;
          if (complete) begin
            state    <= SYNC;
            expected <= '0;
          end else begin
            state    <= ASSEMBLE;
            expected <= cap_idx + IW'(1);
          end
        end else begin
          state        <= SYNC;
          expected     <= '0;
          stage_digits <= '0;
          stage_blank  <= '0;
          stage_err    <= '0;
        end
      end

      if (complete && (!bus.out_valid || bus.out_ready)) begin
        bus.out_valid  <= 1'b1;
        bus.out_digits <= merged_digits;
        bus.out_blank  <= merged_blank;
        bus.out_err    <= merged_err;
      end else if (complete) begin
        bus.overrun <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_reader.sv
// Self-checking bench for sevenseg_reader: directed vector table, hand sequences and a random scan
// compared every cycle against a sample-history reference model (honours SEVENSEG_READER_HEX_EN).
module tb_sevenseg_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_reader_if #(.NDIGITS(N)) bus ();

  sevenseg_reader #(.NDIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: works on the raw history of samples and a count of in-order digits collected.
  logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [N+6:0]   hist [$];
  int             have = 0;
  logic [4*N-1:0] st_d = '0;
  logic [N-1:0]   st_b = '0;
  logic [N-1:0]   st_e = '0;
  logic           m_valid = 1'b0;
  logic           m_overrun = 1'b0;
  logic [4*N-1:0] m_digits = '0;
  logic [N-1:0]   m_blank = '0;
  logic [N-1:0]   m_err = '0;

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] v, output logic b, output logic e);
    int lim;
`ifdef SEVENSEG_READER_HEX_EN
    lim = 16;
`else
    lim = 10;
`endif
    v = 4'hF; b = 1'b0; e = 1'b1;
    if (p == 7'h00) begin
      v = 4'h0; b = 1'b1; e = 1'b0;
    end else begin
      for (int k = 0; k < lim; k++)
        if (pat_tab[k] == p) begin v = 4'(k); e = 1'b0; end
    end
  endtask

  task automatic model_step();
    logic [N+6:0] smp;
    bit           cap;
    bit           done;
    int           idx;
    logic [3:0]   v;
    logic         b, e;
    if (reset) begin
      hist.delete();
      have = 0; st_d = '0; st_b = '0; st_e = '0;
      m_valid = 1'b0; m_overrun = 1'b0; m_digits = '0; m_blank = '0; m_err = '0;
      return;
    end
    smp = {bus.dig_in, bus.seg_in};
    hist.push_back(smp);
    if (hist.size() > S + 1) void'(hist.pop_front());
    cap = 1'b0;
    if (hist.size() >= S && $countones(smp[N+6:7]) == 1) begin
      cap = 1'b1;
      for (int j = hist.size() - S; j < hist.size(); j++)
        if (hist[j] != smp) cap = 1'b0;
      if (hist.size() == S + 1 && hist[0] == smp) cap = 1'b0;
    end
    done = 1'b0;
    if (cap) begin
      idx = 0;
      for (int j = 0; j < N; j++) if (smp[7+j]) idx = j;
      ref_decode(smp[6:0], v, b, e);
      if (idx == 0 || (have > 0 && idx == have)) begin
        st_d[4*idx +: 4] = v; st_b[idx] = b; st_e[idx] = e;
        have = idx + 1;
        if (have == N) begin done = 1'b1; have = 0; end
      end else begin
        have = 0;
      end
    end
    if (done && (!m_valid || bus.out_ready)) begin
      m_valid = 1'b1; m_digits = st_d; m_blank = st_b; m_err = st_e;
    end else if (done) begin
      m_overrun = 1'b1;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("model_valid",   bus.out_valid,  m_valid);
    check("model_overrun", bus.overrun,    m_overrun);
    check("model_digits",  bus.out_digits, m_digits);
    check("model_flags",   {bus.out_blank, bus.out_err}, {m_blank, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic hold(input logic [N-1:0] d, input logic [6:0] p, input int cycles);
    bus.dig_in = d;
    bus.seg_in = p;
    repeat (cycles) tick();
  endtask

  task automatic scan(input logic [7*N-1:0] pats, input int dwell);
    for (int d = 0; d < N; d++) hold(N'(1) << d, pats[7*d +: 7], dwell);
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    tick();
    check(name, bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [27:0] pats;
    int          dwell;
    logic        exp_valid;
    logic [15:0] exp_digits;
    logic [3:0]  exp_blank;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{{7'h33, 7'h79, 7'h6D, 7'h30}, 6, 1'b1, 16'h4321, 4'b0000, 4'b0000};
    vecs[1] = '{{7'h33, 7'h79, 7'h6D, 7'h30}, 3, 1'b0, 16'h0000, 4'b0000, 4'b0000};
    vecs[2] = '{{7'h7F, 7'h70, 7'h5F, 7'h5B}, 4, 1'b1, 16'h8765, 4'b0000, 4'b0000};
    vecs[3] = '{{7'h7F, 7'h00, 7'h7E, 7'h73}, 6, 1'b1, 16'h8009, 4'b0100, 4'b0000};
`ifdef SEVENSEG_READER_HEX_EN
    vecs[4] = '{{7'h79, 7'h77, 7'h00, 7'h7E}, 6, 1'b1, 16'h3A00, 4'b0010, 4'b0000};
    vecs[5] = '{{7'h1F, 7'h4E, 7'h3D, 7'h47}, 5, 1'b1, 16'hBCDF, 4'b0000, 4'b0000};
`else
    vecs[4] = '{{7'h79, 7'h77, 7'h00, 7'h7E}, 6, 1'b1, 16'h3F00, 4'b0010, 4'b0100};
    vecs[5] = '{{7'h1F, 7'h4E, 7'h3D, 7'h47}, 5, 1'b1, 16'hFFFF, 4'b0000, 4'b1111};
`endif
    vecs[6] = '{{7'h5B, 7'h01, 7'h5F, 7'h70}, 7, 1'b1, 16'h5F67, 4'b0000, 4'b0100};

    reset = 1'b1;
    bus.seg_in = '0;
    bus.dig_in = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_valid",   bus.out_valid,  1'b0);
    check("reset_digits",  bus.out_digits, '0);
    check("reset_flags",   {bus.out_blank, bus.out_err}, '0);
    check("reset_overrun", bus.overrun,    1'b0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      scan(vecs[i].pats, vecs[i].dwell);
      hold('0, 7'h00, 2);
      check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_digits", i), bus.out_digits, vecs[i].exp_digits);
        check($sformatf("vec%0d_blank", i),  bus.out_blank,  vecs[i].exp_blank);
        check($sformatf("vec%0d_err", i),    bus.out_err,    vecs[i].exp_err);
      end
      drain($sformatf("vec%0d_drain", i));
    end

    // Out-of-order scan abandons the frame; the next clean scan still completes.
    hold(4'b0001, 7'h30, 6);
    hold(4'b0100, 7'h79, 6);
    hold('0, 7'h00, 2);
    check("skip_novalid", bus.out_valid, 1'b0);
    scan({7'h7F, 7'h70, 7'h5F, 7'h5B}, 6);
    hold('0, 7'h00, 2);
    check("skip_valid",  bus.out_valid,  1'b1);
    check("skip_digits", bus.out_digits, 16'h8765);
    drain("skip_drain");

    // Two frames with the consumer stalled: the first is held, the second overruns.
    scan({7'h33, 7'h79, 7'h6D, 7'h30}, 6);
    scan({7'h7F, 7'h70, 7'h5F, 7'h5B}, 6);
    hold('0, 7'h00, 2);
    check("ovr_valid",   bus.out_valid,  1'b1);
    check("ovr_digits",  bus.out_digits, 16'h4321);
    check("ovr_overrun", bus.overrun,    1'b1);
    drain("ovr_drain");
    check("ovr_sticky",  bus.overrun,    1'b1);

    // Reset in the middle of a frame.
    hold(4'b0001, 7'h30, 6);
    hold(4'b0010, 7'h6D, 6);
    hold(4'b0100, 7'h79, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid",   bus.out_valid,  1'b0);
    check("midrst_digits",  bus.out_digits, '0);
    check("midrst_flags",   {bus.out_blank, bus.out_err}, '0);
    check("midrst_overrun", bus.overrun,    1'b0);
    scan({7'h5F, 7'h70, 7'h7F, 7'h73}, 6);
    hold('0, 7'h00, 2);
    check("midrst_fvalid",  bus.out_valid,  1'b1);
    check("midrst_fdigits", bus.out_digits, 16'h6789);
    drain("midrst_drain");

    // Random scanning against the model.
    begin
      int          order;
      int          r;
      int          dwell;
      logic [N-1:0] d;
      logic [6:0]  p;
      order = 0;
      for (int s = 0; s < 1500; s++) begin
        r = $urandom_range(0, 99);
        if (r < 75) begin
          d = N'(1) << order;
          order = (order + 1) % N;
        end else if (r < 85) begin
          d = N'(1) << $urandom_range(0, N - 1);
        end else if (r < 92) begin
          d = '0;
        end else begin
          d = N'($urandom_range(0, (1 << N) - 1));
        end
        r = $urandom_range(0, 19);
        if (r < 16)       p = pat_tab[r];
        else if (r == 16) p = 7'h00;
        else              p = 7'($urandom_range(0, 127));
        dwell = $urandom_range(1, 7);
        bus.dig_in = d;
        bus.seg_in = p;
        for (int c = 0; c < dwell; c++) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          reset = ($urandom_range(0, 299) == 0);
          tick();
        end
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
